// File: rtl/wb_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_tester_pkg
// Description : Shared types and constants for the Wishbone memory tester.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_tester_pkg;

  // Sequencer states of the tester
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Error cause reported on err_code_o
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Every transfer is a full 32-bit word
  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/wb_mem_tester_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_tester_if
// Description : Wishbone classic bus bundle between tester (master) and
//               memory slave. Signal suffixes are from the master's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_mem_tester_if #(
  parameter int AW = 32
);
  logic [AW-1:0] adr_o;
  logic [31:0]   dat_o;
  logic [31:0]   dat_i;
  logic [3:0]    sel_o;
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic          ack_i;
  logic          err_i;
  logic          rty_i;

  modport master (
    output adr_o, dat_o, sel_o, cyc_o, stb_o, we_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, cyc_o, stb_o, we_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_single_xfer.sv
`default_nettype none
// ============================================================================
// Module      : wb_single_xfer
// Description : Drives one Wishbone classic single transfer. Holds the bus
//               request stable until a termination, handles retry reissue,
//               and flags ack / bus error / retry exhaustion / timeout.
//               Result flags are valid in the cycle the termination is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_single_xfer
  import wb_tester_pkg::*;
#(
  parameter int AW        = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_adr,
  input  logic [31:0]   i_dat,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_adr,
  output logic [31:0]   o_dat,
  output logic [3:0]    o_sel,
  input  logic [31:0]   i_rdat,
  input  logic          i_ack,
  input  logic          i_err,
  input  logic          i_rty,
  output logic          o_done,
  output logic          o_err,
  output logic          o_rty,
  output logic          o_timeout,
  output logic [31:0]   o_rdata
);

  localparam int c_wait_w  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int c_retry_w = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [c_wait_w-1:0]  c_wait_last = c_wait_w'(TIMEOUT - 1);
  localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(MAX_RETRY);

  logic                 r_cyc;
  logic                 r_we;
  logic [AW-1:0]        r_adr;
  logic [31:0]          r_dat;
  logic [c_wait_w-1:0]  r_wait;
  logic [c_retry_w-1:0] r_retry;
  logic                 r_rearm;

  logic w_err;
  logic w_rty;
  logic w_ack;
  logic w_rty_last;
  logic w_tmo;

  // Termination decode with priority err > rty > ack
  assign w_err      = r_cyc & i_err;
  assign w_rty      = r_cyc & ~i_err & i_rty;
  assign w_ack      = r_cyc & ~i_err & ~i_rty & i_ack;
  assign w_rty_last = w_rty & (r_retry == c_retry_max);
  assign w_tmo      = r_cyc & ~i_err & ~i_rty & ~i_ack & (r_wait == c_wait_last);

  assign o_cyc     = r_cyc;
  assign o_stb     = r_cyc;
  assign o_we      = r_we;
  assign o_adr     = r_adr;
  assign o_dat     = r_dat;
  assign o_sel     = SEL_ALL;
  assign o_done    = w_ack;
  assign o_err     = w_err;
  assign o_rty     = w_rty_last;
  assign o_timeout = w_tmo;
  assign o_rdata   = i_rdat;

  // Request launch, hold, retry gap/reissue and wait counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_wait  <= '0;
      r_retry <= '0;
      r_rearm <= 1'b0;
    end else if (i_req) begin
      r_cyc   <= 1'b1;
      r_we    <= i_we;
      r_adr   <= i_adr;
      r_dat   <= i_dat;
      r_wait  <= '0;
      r_retry <= '0;
      r_rearm <= 1'b0;
    end else if (r_cyc) begin
      if (w_rty && !w_rty_last) begin
        // one idle cycle, then the same transfer goes out again
        r_cyc   <= 1'b0;
        r_rearm <= 1'b1;
        r_retry <= r_retry + 1'b1;
        r_wait  <= '0;
      end else if (w_err || w_rty_last || w_ack || w_tmo) begin
        r_cyc <= 1'b0;
      end else begin
        r_wait <= r_wait + 1'b1;
      end
    end else if (r_rearm) begin
      r_cyc   <= 1'b1;
      r_rearm <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_mem_tester.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_tester
// Description : Wishbone memory self-test master. Writes seed+i to word i of
//               a range, reads the range back, and reports the first failure.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_tester
  import wb_tester_pkg::*;
#(
  parameter int AW        = 32,
  parameter int LW        = 16,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 7
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [AW-1:0]  base_i,
  input  logic [LW-1:0]  len_i,
  input  logic [31:0]    seed_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           pass_o,
  output logic [1:0]     err_code_o,
  output logic [AW-1:0]  fail_adr_o,
  output logic [31:0]    fail_dat_o,
  wb_mem_tester_if.master wb
);

  state_t        r_state;
  logic [LW-1:0] r_i;
  logic [LW-1:0] r_len;
  logic [AW-1:0] r_base;
  logic [31:0]   r_seed;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [1:0]    r_code;
  logic [AW-1:0] r_fail_adr;
  logic [31:0]   r_fail_dat;

  logic          w_launch;
  logic          w_launch_we;
  logic [LW-1:0] w_launch_i;
  logic [AW-1:0] w_src_base;
  logic [31:0]   w_src_seed;
  logic [AW-1:0] w_launch_adr;
  logic [31:0]   w_launch_dat;
  logic [AW-1:0] w_base_in;
  logic [AW-1:0] w_cur_adr;
  logic [31:0]   w_exp_dat;
  logic [LW-1:0] w_next_i;
  logic          w_last;
  logic          w_x_done;
  logic          w_x_err;
  logic          w_x_rty;
  logic          w_x_tmo;
  logic [31:0]   w_x_rdata;
  logic          w_mismatch;
  logic          w_abort;

  assign w_base_in  = base_i & ~AW'(3);
  assign w_next_i   = r_i + 1'b1;
  assign w_last     = (r_i == r_len - 1'b1);
  assign w_cur_adr  = r_base + AW'({r_i, 2'b00});
  assign w_exp_dat  = r_seed + 32'(r_i);
  assign w_mismatch = w_x_done && (r_state == RD_REQ) && (w_x_rdata != w_exp_dat);
  assign w_abort    = w_x_err || w_x_rty || w_x_tmo || w_mismatch;

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign pass_o     = r_pass;
  assign err_code_o = r_code;
  assign fail_adr_o = r_fail_adr;
  assign fail_dat_o = r_fail_dat;

  // Next transfer to launch, so the request rises on the same edge the FSM enters a REQ state
  always_comb begin
    w_launch    = 1'b0;
    w_launch_we = 1'b0;
    w_launch_i  = '0;
    w_src_base  = r_base;
    w_src_seed  = r_seed;
    case (r_state)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          w_launch    = 1'b1;
          w_launch_we = 1'b1;
          w_src_base  = w_base_in;
          w_src_seed  = seed_i;
        end
      end
      WR_GAP: begin
        w_launch    = 1'b1;
        w_launch_we = !w_last;
        w_launch_i  = w_last ? '0 : w_next_i;
      end
      RD_GAP: begin
        w_launch   = !w_last;
        w_launch_i = w_next_i;
      end
      default: ;
    endcase
  end

  assign w_launch_adr = w_src_base + AW'({w_launch_i, 2'b00});
  assign w_launch_dat = w_src_seed + 32'(w_launch_i);

  wb_single_xfer #(
    .AW        (AW),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) u_xfer (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .i_req     (w_launch),
    .i_we      (w_launch_we),
    .i_adr     (w_launch_adr),
    .i_dat     (w_launch_dat),
    .o_cyc     (wb.cyc_o),
    .o_stb     (wb.stb_o),
    .o_we      (wb.we_o),
    .o_adr     (wb.adr_o),
    .o_dat     (wb.dat_o),
    .o_sel     (wb.sel_o),
    .i_rdat    (wb.dat_i),
    .i_ack     (wb.ack_i),
    .i_err     (wb.err_i),
    .i_rty     (wb.rty_i),
    .o_done    (w_x_done),
    .o_err     (w_x_err),
    .o_rty     (w_x_rty),
    .o_timeout (w_x_tmo),
    .o_rdata   (w_x_rdata)
  );

  // Test sequencer: write phase, read/compare phase, result reporting
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_len      <= '0;
      r_base     <= '0;
      r_seed     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_code     <= ERR_NONE;
      r_fail_adr <= '0;
      r_fail_dat <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_base     <= w_base_in;
            r_len      <= len_i;
            r_seed     <= seed_i;
            r_i        <= '0;
            r_code     <= ERR_NONE;
            r_fail_adr <= '0;
            r_fail_dat <= '0;
            r_pass     <= 1'b0;
            if (len_i == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= WR_REQ;
              r_busy  <= 1'b1;
            end
          end
        end
        WR_REQ, RD_REQ: begin
          if (w_abort) begin
            r_state    <= FINISH;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_adr <= w_cur_adr;
            r_fail_dat <= w_mismatch ? w_x_rdata : '0;
            if (w_x_err)
              r_code <= ERR_BUS;
            else if (w_x_rty || w_x_tmo)
              r_code <= ERR_TIMEOUT;
            else
              r_code <= ERR_MISMATCH;
          end else if (w_x_done) begin
            r_state <= (r_state == WR_REQ) ? WR_GAP : RD_GAP;
          end
        end
        WR_GAP: begin
          if (w_last) begin
            r_i     <= '0;
            r_state <= RD_REQ;
          end else begin
            r_i     <= w_next_i;
            r_state <= WR_REQ;
          end
        end
        RD_GAP: begin
          if (w_last) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= 1'b1;
          end else begin
            r_i     <= w_next_i;
            r_state <= RD_REQ;
          end
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_mem_tester.md
Name: wb_mem_tester

Overview:
- Wishbone classic single-transfer master: the initiator end of the bus that wb_ram_32x512 answers as a slave.
- On a start pulse it writes a deterministic pattern over a word range, then reads the range back and compares each word.
- Reports pass/fail, first failing address/data and error cause.
- Used as on-chip self-test for Wishbone RAM slaves; replaces the behavioural bus master in system-level benches.

Parameters:
- AW, 32, Wishbone address width (byte address).
- LW, 16, width of the word-count input.
- TIMEOUT, 255, max cycles to wait for ack/err/rty per transfer (≥1).
- MAX_RETRY, 7, max consecutive rty_i responses tolerated per transfer.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; sampled only in IDLE.
- base_i  in  AW  byte start address; bits [1:0] ignored (forced 0).
- len_i  in  LW  number of 32-bit words.
- seed_i  in  32  pattern seed.
- busy_o  out  1  high from start acceptance until done.
- done_o  out  1  one-cycle pulse at completion.
- pass_o  out  1  result of last run, held until next start.
- err_code_o  out  2  0 none, 1 data mismatch, 2 bus err_i, 3 timeout/retry exhausted.
- fail_adr_o  out  AW  address of first failure.
- fail_dat_o  out  32  data read at mismatch (0 for other codes).
- adr_o  out  AW  Wishbone address.
- dat_o  out  32  write data.
- dat_i  in  32  read data.
- sel_o  out  4  byte selects, always 4'hF.
- cyc_o, stb_o, we_o  out  1  Wishbone cycle/strobe/write.
- ack_i, err_i, rty_i  in  1  slave terminations.

Behaviour:
- Reset (rst_i low, async): state IDLE; cyc_o/stb_o/we_o/busy_o/done_o/pass_o = 0; err_code_o = 0; adr_o/dat_o/fail_adr_o/fail_dat_o = 0.
- Reset mid-transfer drops cyc_o/stb_o immediately; no completion pulse.
- Pattern:
  - word i at byte address base + 4*i (AW-bit wrap) carries data = seed_i + i, 32-bit wrap.
  - base, len and seed are latched at start.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH.
- IDLE, start_i=1:
  - latch inputs; clear err_code_o/fail_*; busy_o=1.
  - len=0 → FINISH directly (pass).
  - otherwise → WR_REQ with i=0.
- start_i while busy: ignored.
- WR_REQ:
  - cyc_o=stb_o=we_o=1 with adr/dat valid, held stable until a termination.
  - ack_i → drop cyc/stb next cycle, go WR_GAP.
  - err_i → abort (code 2).
  - rty_i → drop for one cycle, reissue the same transfer; the retry counter increments. Exceeding MAX_RETRY → abort (code 3).
  - wait counter reaching TIMEOUT with no termination → abort (code 3).
- Termination priority when several are asserted in the same cycle: err_i > rty_i > ack_i.
- WR_GAP (1 cycle, cyc/stb low):
  - i == len-1 → reset i, go RD_REQ.
  - else i+1, go WR_REQ.
- RD_REQ: same as WR_REQ with we_o=0.
  - On ack_i, sample dat_i and compare to seed+i.
  - Mismatch → record adr/dat, abort (code 1); first failure only.
- RD_GAP: i == len-1 → FINISH; else i+1, go RD_REQ.
- Abort: drop cyc/stb the next cycle, go FINISH with pass_o=0.
- FINISH (1 cycle): done_o=1, busy_o=0, pass_o=(err_code==0), → IDLE.
- Throughput: each transfer occupies ≥2 cycles (request + gap); cyc_o is never held across transfers.
- Write phase wraps the address space silently; the same words are read back.

Decomposition:
- Package wb_tester_pkg: state enum, err-code constants (ERR_NONE/ERR_MISMATCH/ERR_BUS/ERR_TIMEOUT), SEL_ALL=4'hF.
- One natural sub-module, wb_single_xfer: drives one classic transfer, with req/we/adr/dat in and done/err/rty/timeout/rdata out, and owns the wait and retry counters. The top FSM sequences it.

Test Plan:
- wb_ram_32x512 slave, base 0x000, len 16, seed 0xA5A50000 → 16 writes then 16 reads; done_o pulse; pass_o=1, err_code_o=0; RAM word 5 = 0xA5A50005.
- len 0, start → done_o one cycle after start acceptance, pass_o=1, no cyc_o activity.
- Slave model corrupts read of address 0x01C (xor 0x1) with base 0, seed 0 → pass_o=0, err_code 1, fail_adr 0x01C, fail_dat 0x00000006; no further transfers.
- Slave asserts err_i on 3rd write → err_code 2, fail_adr 0x008, cyc_o low next cycle.
- Slave never acks, TIMEOUT=8 → abort after 8 waiting cycles, err_code 3. A separate run with rty_i asserted 8 times in a row also ends with err_code 3.
- rst_i low during RD_REQ of a 64-word run → cyc_o/stb_o/busy_o low immediately, no done_o. A fresh start then completes with pass_o=1.
